// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Two requesters share one single-cycle ALU. An arbiter picks at most one
// requester per cycle, the chosen operation is evaluated combinationally and
// the result is captured in a one-entry result register. The register is
// drained by a valid/ready consumer.
//
// Arbitration is round-robin by default. Defining the macro
// ALU_ARBITER_FIXED_PRIO_EN switches to fixed priority, where requester 0
// always wins a contention and no priority pointer exists.
//
// Parameters
//   WIDTH          operand / result width in bits (>= 2)
//
// Ports
//   clk_i          clock, all state updates on the rising edge
//   rst_i          synchronous active-high reset
//   req0_valid_i   requester 0 offers an operation
//   req0_ready_o   requester 0 operation accepted this cycle
//   req0_first_i   requester 0 first operand
//   req0_second_i  requester 0 second operand (also the shift amount)
//   req0_opcode_i  requester 0 operation code
//   req1_*         same set for requester 1
//   res_valid_o    result register holds an undelivered result
//   res_ready_i    consumer takes the result this cycle
//   res_data_o     registered result
//   res_id_o       index of the requester that issued the held result
//
// Opcodes
//   000 NAND   001 XOR   010 ADD   011 SRA first by second
//   100 OR     101 SHL first by second   110 NOT first
//   111 unsigned first < second (1/0, zero-extended)
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [WIDTH-1:0] req0_first_i,
    input  logic [WIDTH-1:0] req0_second_i,
    input  logic [2:0]       req0_opcode_i,

    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [WIDTH-1:0] req1_first_i,
    input  logic [WIDTH-1:0] req1_second_i,
    input  logic [2:0]       req1_opcode_i,

    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [WIDTH-1:0] res_data_o,
    output logic             res_id_o
);

    localparam logic [2:0] OP_NAND = 3'b000;
    localparam logic [2:0] OP_XOR  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SRA  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_SHL  = 3'b101;
    localparam logic [2:0] OP_NOT  = 3'b110;
    localparam logic [2:0] OP_LTU  = 3'b111;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic             can_accept;
    logic             grant0;
    logic             grant1;
    logic             accept;
    logic             sel_id;
    logic [WIDTH-1:0] sel_first;
    logic [WIDTH-1:0] sel_second;
    logic [2:0]       sel_opcode;
    logic [WIDTH-1:0] alu_result;

    logic [WIDTH-1:0] res_data_q;
    logic             res_id_q;

    // -------------------------------------------------------------------------
    // ALU. The full second operand is the shift amount; the language already
    // gives zero for a logical shift by >= WIDTH and sign fill for an
    // arithmetic shift by >= WIDTH, which is exactly the required saturation.
    // -------------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] alu_eval(
        input logic [2:0]       opcode,
        input logic [WIDTH-1:0] first,
        input logic [WIDTH-1:0] second
    );
        logic signed [WIDTH-1:0] first_s;
        logic        [WIDTH-1:0] result;
        first_s = $signed(first);
        result  = '0;
        case (opcode)
            OP_NAND: result = ~(first & second);
            OP_XOR:  result = first ^ second;
            OP_ADD:  result = first + second;
            OP_SRA:  result = $unsigned(first_s >>> second);
            OP_OR:   result = first | second;
            OP_SHL:  result = first << second;
            OP_NOT:  result = ~first;
            OP_LTU:  result = {{(WIDTH-1){1'b0}}, (first < second)};
            default: result = '0;
        endcase
        return result;
    endfunction

    // -------------------------------------------------------------------------
    // Arbitration: grant0/grant1 say who would win if a slot were free.
    // -------------------------------------------------------------------------
`ifdef ALU_ARBITER_FIXED_PRIO_EN
    always_comb begin
        grant0 = req0_valid_i;
        grant1 = req1_valid_i & ~req0_valid_i;
    end
`else
    // prio_q names the favoured requester for the next contention.
    logic prio_q;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (prio_q == 1'b0) begin
            grant0 = req0_valid_i;
            grant1 = req1_valid_i & ~req0_valid_i;
        end else begin
            grant1 = req1_valid_i;
            grant0 = req0_valid_i & ~req1_valid_i;
        end
    end

    // After a grant the other requester becomes favoured.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q <= 1'b0;
        end else if (accept) begin
            prio_q <= ~sel_id;
        end
    end
`endif

    // A slot is free when the register is empty or is being drained this
    // cycle; reset blocks any acceptance.
    assign can_accept   = ~rst_i & ((state_q == EMPTY) | res_ready_i);
    assign req0_ready_o = can_accept & grant0;
    assign req1_ready_o = can_accept & grant1;
    assign accept       = req0_ready_o | req1_ready_o;

    // Operands are only sampled from the accepted requester.
    assign sel_id     = req1_ready_o;
    assign sel_first  = sel_id ? req1_first_i  : req0_first_i;
    assign sel_second = sel_id ? req1_second_i : req0_second_i;
    assign sel_opcode = sel_id ? req1_opcode_i : req0_opcode_i;
    assign alu_result = alu_eval(sel_opcode, sel_first, sel_second);

    // -------------------------------------------------------------------------
    // Result FSM
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (!accept && res_ready_i) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Result register: loads on acceptance, otherwise holds (also across a
    // drain, so the last value stays visible while EMPTY).
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            res_data_q <= '0;
            res_id_q   <= 1'b0;
        end else if (accept) begin
            res_data_q <= alu_result;
            res_id_q   <= sel_id;
        end
    end

    assign res_valid_o = (state_q == FULL);
    assign res_data_o  = res_data_q;
    assign res_id_o    = res_id_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (WIDTH >= 2).
REQ-002 SHALL have clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have req0_valid_i  input  1  requester 0 offers an operation.
REQ-005 SHALL have req0_ready_o  output  1  requester 0 operation accepted this cycle.
REQ-006 SHALL have req0_first_i, req0_second_i  input  WIDTH each  requester 0 operands.
REQ-007 SHALL have req0_opcode_i  input  3  requester 0 operation code.
REQ-008 SHALL have req1_valid_i, req1_ready_o, req1_first_i, req1_second_i, req1_opcode_i, identical to REQ-004..007, for requester 1.
REQ-009 SHALL have res_valid_o  output  1  result register holds an undelivered result.
REQ-010 SHALL have res_ready_i  input  1  consumer takes the result this cycle.
REQ-011 SHALL have res_data_o  output  WIDTH  registered result.
REQ-012 SHALL have res_id_o  output  1  requester index that issued the held result.

Function
REQ-013 SHALL implement opcodes: 000 NAND, 001 XOR, 010 ADD (mod 2^WIDTH), 011 arithmetic shift right of first by second, 100 OR, 101 logical shift left of first by second, 110 NOT first, 111 unsigned first<second giving 1 or 0 zero-extended.
REQ-014 SHALL use the full second operand as shift amount; amounts >= WIDTH yield all-zero (shl) or all copies of first's MSB (sra).
REQ-015 SHALL run a two-state FSM: EMPTY (res_valid_o=0) and FULL (res_valid_o=1).
REQ-016 SHALL define can_accept = EMPTY, or FULL with res_ready_i=1.
REQ-017 SHALL assert at most one of req0_ready_o/req1_ready_o per cycle, only when can_accept and that requester's valid is 1 and it wins arbitration; ready is combinational from valids, state and res_ready_i.
REQ-018 SHALL, on acceptance in cycle N, present the result, res_id_o and res_valid_o=1 from the edge ending cycle N (latency 1 cycle); FSM goes to/stays FULL.
REQ-019 SHALL, in FULL with res_ready_i=1 and no acceptance, go to EMPTY; res_data_o/res_id_o hold their last values.
REQ-020 SHALL hold res_data_o, res_id_o, res_valid_o stable while FULL and res_ready_i=0.
REQ-021 SHALL arbitrate round-robin: a priority pointer names the favoured requester; a lone valid requester wins; when both are valid, the favoured one wins; after each grant the pointer moves to the other requester; no grant, no pointer change.
REQ-022 SHALL sustain one accepted operation per cycle when res_ready_i is held 1.
REQ-023 SHALL ignore operands and opcode of non-accepted requesters; a requester keeping valid=1 is not required to hold operands stable, but the arbiter samples only on acceptance.

Reset
REQ-024 SHALL, when rst_i=1 at a rising edge, set FSM to EMPTY, res_valid_o=0, res_data_o=0, res_id_o=0, pointer favouring requester 0, overriding any simultaneous acceptance or delivery.
REQ-025 SHALL drive both ready outputs 0 in any cycle where rst_i=1; a held result is discarded by reset.

Configuration
REQ-026 SHALL, when macro ALU_ARBITER_FIXED_PRIO_EN is defined, replace round-robin with fixed priority: requester 0 always wins when both are valid, pointer logic absent.
REQ-027 SHALL, without ALU_ARBITER_FIXED_PRIO_EN, use round-robin per REQ-021; all other behaviour identical.

Verification
REQ-028 SHALL cover: after reset, req0 valid, first=8'h0F, second=8'h01, opcode=010, res_ready_i=1 -> req0_ready_o=1 same cycle; next cycle res_valid_o=1, res_data_o=8'h10, res_id_o=0.
REQ-029 SHALL cover: both valid continuously, res_ready_i=1, round-robin build -> grants alternate 0,1,0,1; fixed-priority build -> req0 every cycle, req1 never.
REQ-030 SHALL cover: result FULL, res_ready_i=0 for 3 cycles with both valid -> both readys 0, res_data_o unchanged; res_ready_i=1 -> same-cycle acceptance and new result next cycle.
REQ-031 SHALL cover: opcode 011 first=8'h80 second=8'd9 -> 8'hFF; opcode 101 first=8'h01 second=8'd8 -> 8'h00; opcode 111 first=8'hFF second=8'h01 -> 8'h00.
REQ-032 SHALL cover: rst_i=1 in a cycle with FULL state, res_ready_i=1 and req1 valid -> no ready asserted; next cycle res_valid_o=0, res_data_o=0, res_id_o=0; next contention grants req0.
